// File: rtl/sync_fifo_rd_adapter.sv
// Pops sync_fifo words (1-cycle read latency), buffers two, emits RATIO beats LSB-first; first beat 2 cycles after pop.
// Pops are gated purely by buffer credits (count + pend < 2), so consumer backpressure never drops or duplicates a word.
module sync_fifo_rd_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_empty,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
      $error("sync_fifo_rd_adapter: DATA_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  function automatic logic [OUT_WIDTH-1:0] f_slice(input logic [DATA_WIDTH-1:0] word,
                                                   input logic [BW-1:0] idx);
    logic [OUT_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx == BW'(k)) s = word[k*OUT_WIDTH +: OUT_WIDTH];
    end
    return s;
  endfunction

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_pend;
  logic [BW-1:0]         r_beat;
  state_t                r_state;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;

  logic [2:0]            w_occ;
  logic                  w_rd_en;
  logic                  w_accept;
  logic                  w_beat_end;
  logic                  w_free;
  logic                  w_has_next;
  logic [BW-1:0]         w_beat_inc;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_first_word;
  logic [DATA_WIDTH-1:0] w_next_word;
  logic [1:0]            w_count_nxt;

  assign w_occ      = {1'b0, r_count} + {2'b00, r_pend};
  assign w_rd_en    = i_rstn & ~i_empty & (w_occ < 3'd2);
  assign w_accept   = r_valid & i_ready;
  assign w_beat_end = (r_beat == BW'(RATIO - 1));
  assign w_free     = w_accept & w_beat_end;
  assign w_has_next = (r_count >= 2'd2) | r_pend;
  assign w_beat_inc = r_beat + BW'(1);
  assign w_head     = r_buf[r_rd_ptr];
  // A word arriving this cycle is forwarded straight from the FIFO so the first beat costs no extra cycle.
  assign w_first_word = (r_count != 2'd0) ? w_head : i_rd_data;
  assign w_next_word  = (r_count >= 2'd2) ? r_buf[~r_rd_ptr] : i_rd_data;

  always_comb begin
    w_count_nxt = r_count;
    if (r_pend && !w_free) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!r_pend && w_free) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_pend   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (r_pend) begin
        r_buf[r_wr_ptr] <= i_rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_free) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_nxt;
      r_pend  <= w_rd_en;
      r_busy  <= (w_count_nxt != 2'd0) | w_rd_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((r_count != 2'd0) || r_pend) begin
            r_beat  <= '0;
            r_data  <= f_slice(w_first_word, '0);
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (!w_beat_end) begin
              r_beat <= w_beat_inc;
              r_data <= f_slice(w_head, w_beat_inc);
              r_last <= (w_beat_inc == BW'(RATIO - 1));
            end else if (w_has_next) begin
              r_beat <= '0;
              r_data <= f_slice(w_next_word, '0);
              r_last <= 1'b0;
            end else begin
              r_beat  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_en = w_rd_en;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = r_busy;

endmodule
